// File: rtl/seg7_pkg.sv
// seg7_pkg: glyph codes, active-low segment patterns and FSM states
// shared by the 7-segment message driver and its glyph decoder.
package seg7_pkg;

    localparam logic [4:0] G_P     = 5'd10;
    localparam logic [4:0] G_A     = 5'd11;
    localparam logic [4:0] G_S     = 5'd12;
    localparam logic [4:0] G_E     = 5'd13;
    localparam logic [4:0] G_DASH  = 5'd14;
    localparam logic [4:0] G_BLANK = 5'd15;

    // Segment order {g,f,e,d,c,b,a}, 0 = lit.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_P     = 7'b0001100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_S     = 7'b0010010;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_BAD   = 7'b0011000;

    typedef enum logic [1:0] {
        ST_STATIC = 2'd0,
        ST_SCROLL = 2'd1,
        ST_PAUSE  = 2'd2
    } state_t;

endpackage

// File: rtl/seg7_glyph_decode.sv
// seg7_glyph_decode: 5-bit glyph code to 7-bit active-low segments.
// Ports: code (glyph code in), seg ({g,f,e,d,c,b,a} out, 0 = lit).
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [4:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BAD;
        case (code)
            5'd0:    seg = SEG_0;
            5'd1:    seg = SEG_1;
            5'd2:    seg = SEG_2;
            5'd3:    seg = SEG_3;
            5'd4:    seg = SEG_4;
            5'd5:    seg = SEG_5;
            5'd6:    seg = SEG_6;
            5'd7:    seg = SEG_7;
            5'd8:    seg = SEG_8;
            5'd9:    seg = SEG_9;
            G_P:     seg = SEG_P;
            G_A:     seg = SEG_A;
            G_S:     seg = SEG_S;
            G_E:     seg = SEG_E;
            G_DASH:  seg = SEG_DASH;
            G_BLANK: seg = SEG_BLANK;
            default: seg = SEG_BAD;
        endcase
    end

endmodule

// File: rtl/seg7_msg_display.sv
// seg7_msg_display: glyph message buffer shown as an N_DIGITS window
// on active-low 7-segment outputs, with static, scroll/pause and blink.
// Ports: clk, rst (sync, high); wr_en/wr_addr/wr_code buffer write;
// scroll_en, hold, scroll_len scroll control; blink_mask per digit;
// hex registered segments (digit 0 rightmost); scroll_wrap pulse.
module seg7_msg_display
    import seg7_pkg::*;
#(
    parameter int N_DIGITS  = 6,
    parameter int MSG_LEN   = 16,
    parameter int CLK_HZ    = 50_000_000,
    parameter int BLINK_HZ  = 2,
    parameter int SCROLL_HZ = 4,
    localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [4:0]            wr_code,
    input  logic                  scroll_en,
    input  logic                  hold,
    input  logic [AW:0]           scroll_len,
    input  logic [N_DIGITS-1:0]   blink_mask,
    output logic [7*N_DIGITS-1:0] hex,
    output logic                  scroll_wrap
);

    localparam int LW         = AW + 1;
    localparam int BLINK_DIV  = CLK_HZ / (2 * BLINK_HZ);
    localparam int SCROLL_DIV = CLK_HZ / SCROLL_HZ;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    localparam logic [BW-1:0] BLINK_TOP  = BW'(BLINK_DIV - 1);
    localparam logic [SW-1:0] SCROLL_TOP = SW'(SCROLL_DIV - 1);
    localparam logic [LW-1:0] LEN_MIN    = LW'(N_DIGITS);
    localparam logic [LW-1:0] LEN_MAX    = LW'(MSG_LEN);

    logic [4:0]            msg_q [MSG_LEN];
    state_t                state_q, state_d;
    logic [AW-1:0]         offset_q, offset_d;
    logic [SW-1:0]         spre_q, spre_d;
    logic [BW-1:0]         bpre_q;
    logic                  blink_q;
    logic                  advance;
    logic                  wrap_d;
    logic [LW-1:0]         eff_len;
    logic [7*N_DIGITS-1:0] hex_d;

    always_comb begin
        eff_len = scroll_len;
        if (scroll_len < LEN_MIN) begin
            eff_len = LEN_MIN;
        end else if (scroll_len > LEN_MAX) begin
            eff_len = LEN_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < MSG_LEN; j++) begin
                msg_q[j] <= G_BLANK;
            end
        end else if (wr_en && (LW'(wr_addr) < LEN_MAX)) begin
            msg_q[wr_addr] <= wr_code;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_STATIC: begin
                if (scroll_en) state_d = ST_SCROLL;
            end
            ST_SCROLL: begin
                if (!scroll_en) state_d = ST_STATIC;
                else if (hold)  state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (!scroll_en) state_d = ST_STATIC;
                else if (!hold) state_d = ST_SCROLL;
            end
            default: state_d = ST_STATIC;
        endcase
    end

    // The prescaler only counts on edges that stay in SCROLL, so a
    // hold or exit sampled on an edge freezes/clears that same edge.
    always_comb begin
        offset_d = offset_q;
        spre_d   = spre_q;
        advance  = 1'b0;
        wrap_d   = 1'b0;
        if (state_d == ST_STATIC) begin
            offset_d = '0;
            spre_d   = '0;
        end else begin
            if (state_q == ST_SCROLL && state_d == ST_SCROLL) begin
                if (spre_q == SCROLL_TOP) begin
                    spre_d  = '0;
                    advance = 1'b1;
                end else begin
                    spre_d = spre_q + SW'(1);
                end
            end
            // A shrunk length snaps the window home without a wrap.
            if (LW'(offset_q) >= eff_len) begin
                offset_d = '0;
            end else if (advance) begin
                if (LW'(offset_q) == eff_len - LW'(1)) begin
                    offset_d = '0;
                    wrap_d   = 1'b1;
                end else begin
                    offset_d = offset_q + AW'(1);
                end
            end
        end
    end

    for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
        localparam logic [LW-1:0] K = LW'(N_DIGITS - 1 - i);
        logic [LW-1:0] sum;
        logic [LW-1:0] idx;
        logic [6:0]    seg;

        // offset and k are both below eff_len, so one subtract wraps.
        assign sum = LW'(offset_q) + K;
        assign idx = (sum >= eff_len) ? sum - eff_len : sum;

        seg7_glyph_decode u_dec (
            .code (msg_q[idx[AW-1:0]]),
            .seg  (seg)
        );

        assign hex_d[7*i +: 7] =
            (blink_q && blink_mask[i]) ? SEG_BLANK : seg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_STATIC;
            offset_q    <= '0;
            spre_q      <= '0;
            bpre_q      <= '0;
            blink_q     <= 1'b0;
            hex         <= '1;
            scroll_wrap <= 1'b0;
        end else begin
            state_q     <= state_d;
            offset_q    <= offset_d;
            spre_q      <= spre_d;
            hex         <= hex_d;
            scroll_wrap <= wrap_d;
            if (bpre_q == BLINK_TOP) begin
                bpre_q  <= '0;
                blink_q <= ~blink_q;
            end else begin
                bpre_q <= bpre_q + BW'(1);
            end
        end
    end

endmodule

// File: tb/tb_seg7_msg_display.sv
// tb_seg7_msg_display: randomized and directed checks of the message
// driver against a behavioural edge-count model of the display.
module tb_seg7_msg_display;

    localparam int ND         = 4;
    localparam int ML         = 8;
    localparam int BLINK_DIV  = 4;
    localparam int SCROLL_DIV = 4;
    localparam int M_STATIC   = 0;
    localparam int M_SCROLL   = 1;
    localparam int M_PAUSE    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [4:0]  wr_code;
    logic        scroll_en;
    logic        hold;
    logic [3:0]  scroll_len;
    logic [3:0]  blink_mask;
    logic [27:0] hex;
    logic        scroll_wrap;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg7_msg_display #(
        .N_DIGITS  (ND),
        .MSG_LEN   (ML),
        .CLK_HZ    (8),
        .BLINK_HZ  (1),
        .SCROLL_HZ (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_code     (wr_code),
        .scroll_en   (scroll_en),
        .hold        (hold),
        .scroll_len  (scroll_len),
        .blink_mask  (blink_mask),
        .hex         (hex),
        .scroll_wrap (scroll_wrap)
    );

    function automatic logic [6:0] seg_of(input int c);
        case (c)
            0:  return 7'b1000000;
            1:  return 7'b1111001;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0010000;
            10: return 7'b0001100;
            11: return 7'b0001000;
            12: return 7'b0010010;
            13: return 7'b0000110;
            14: return 7'b0111111;
            15: return 7'b1111111;
            default: return 7'b0011000;
        endcase
    endfunction

    // Reference model: blink phase from edges since reset, scroll
    // from a modulo tick count, window from the message rules.
    int          m_msg [ML];
    int          m_off;
    int          m_spre;
    int          m_mode;
    int          m_bcnt;
    logic [27:0] m_hex;
    logic        m_wrap;

    always @(posedge clk) begin : model
        int eff;
        int nm;
        int off;
        int sp;
        int idx;
        int adv;
        int wr;
        logic [27:0] nh;
        logic [6:0]  g;
        if (rst) begin
            for (int j = 0; j < ML; j++) m_msg[j] <= 15;
            m_hex  <= '1;
            m_wrap <= 1'b0;
            m_off  <= 0;
            m_spre <= 0;
            m_mode <= M_STATIC;
            m_bcnt <= 0;
        end else begin
            eff = int'(scroll_len);
            if (eff < ND) eff = ND;
            if (eff > ML) eff = ML;
            nh = '0;
            for (int i = 0; i < ND; i++) begin
                idx = m_off + (ND - 1 - i);
                if (idx >= eff) idx = idx - eff;
                g = seg_of(m_msg[idx]);
                if (blink_mask[i] && ((m_bcnt / BLINK_DIV) % 2 == 1))
                    g = 7'h7F;
                nh[7*i +: 7] = g;
            end
            nm = m_mode;
            if (m_mode == M_STATIC) begin
                if (scroll_en) nm = M_SCROLL;
            end else if (m_mode == M_SCROLL) begin
                if (!scroll_en) nm = M_STATIC;
                else if (hold)  nm = M_PAUSE;
            end else begin
                if (!scroll_en) nm = M_STATIC;
                else if (!hold) nm = M_SCROLL;
            end
            off = m_off;
            sp  = m_spre;
            wr  = 0;
            adv = 0;
            if (nm == M_STATIC) begin
                off = 0;
                sp  = 0;
            end else begin
                if (m_mode == M_SCROLL && nm == M_SCROLL) begin
                    sp  = (sp + 1) % SCROLL_DIV;
                    adv = (sp == 0);
                end
                if (off >= eff) begin
                    off = 0;
                end else if (adv != 0) begin
                    off = (off + 1) % eff;
                    wr  = (off == 0);
                end
            end
            m_hex  <= nh;
            m_wrap <= (wr != 0);
            m_off  <= off;
            m_spre <= sp;
            m_mode <= nm;
            m_bcnt <= m_bcnt + 1;
            if (wr_en) m_msg[wr_addr] <= int'(wr_code);
        end
    end

    task automatic put(input int a, input int c);
        wr_en   = 1'b1;
        wr_addr = 3'(a);
        wr_code = 5'(c);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (hex !== 28'hFFFFFFF) begin
            errors++;
            $display("FAIL reset_hex got %h want %h", hex, 28'hFFFFFFF);
        end
        checks++;
        if (scroll_wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_wrap got %b want 0", scroll_wrap);
        end
        rst = 1'b0;
        put(0, 7);
        @(negedge clk);
        checks++;
        if (hex !== {7'b1111000, 21'h1FFFFF}) begin
            errors++;
            $display("FAIL first_write got %h want %h",
                     hex, {7'b1111000, 21'h1FFFFF});
        end
    endtask

    task automatic test_static();
        logic [27:0] want;
        put(0, 10);
        put(1, 11);
        put(2, 12);
        put(3, 12);
        @(negedge clk);
        want = {7'b0001100, 7'b0001000, 7'b0010010, 7'b0010010};
        checks++;
        if (hex !== want) begin
            errors++;
            $display("FAIL static_pass got %h want %h", hex, want);
        end
        put(3, 20);
        @(negedge clk);
        checks++;
        if (hex[6:0] !== 7'b0011000) begin
            errors++;
            $display("FAIL static_invalid got %b want 0011000", hex[6:0]);
        end
        checks++;
        if (hex !== m_hex) begin
            errors++;
            $display("FAIL static_model got %h want %h", hex, m_hex);
        end
    endtask

    task automatic test_scroll();
        logic [6:0] seq [$];
        int         at [$];
        logic [6:0] prev;
        logic [27:0] want;
        int wh;
        for (int a = 0; a < ML; a++) put(a, (a < 5) ? a + 1 : 15);
        @(negedge clk);
        scroll_len = 4'd5;
        scroll_en  = 1'b1;
        prev = hex[27:21];
        seq.push_back(prev);
        at.push_back(0);
        wh = 0;
        for (int c = 1; c <= 60 && seq.size() < 6; c++) begin
            @(negedge clk);
            checks++;
            if (hex !== m_hex || scroll_wrap !== m_wrap) begin
                errors++;
                $display("FAIL scroll_model got %h/%b want %h/%b",
                         hex, scroll_wrap, m_hex, m_wrap);
            end
            if (scroll_wrap) wh++;
            if (hex[27:21] !== prev) begin
                prev = hex[27:21];
                seq.push_back(prev);
                at.push_back(c);
                if (prev == seg_of(4)) begin
                    want = {seg_of(4), seg_of(5), seg_of(1), seg_of(2)};
                    checks++;
                    if (hex !== want) begin
                        errors++;
                        $display("FAIL scroll_window got %h want %h",
                                 hex, want);
                    end
                end
            end
        end
        checks++;
        if (seq.size() != 6) begin
            errors++;
            $display("FAIL scroll_timeout got %0d steps want 6", seq.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (seq[i] !== seg_of((i == 5) ? 1 : i + 1)) begin
                    errors++;
                    $display("FAIL scroll_seq[%0d] got %b want %b",
                             i, seq[i], seg_of((i == 5) ? 1 : i + 1));
                end
            end
            for (int i = 2; i < 6; i++) begin
                checks++;
                if (at[i] - at[i-1] != 4) begin
                    errors++;
                    $display("FAIL scroll_period got %0d want 4",
                             at[i] - at[i-1]);
                end
            end
        end
        checks++;
        if (wh != 1) begin
            errors++;
            $display("FAIL scroll_wrap_count got %0d want 1", wh);
        end
    endtask

    task automatic test_pause();
        logic [27:0] ref_hex;
        logic [27:0] want;
        @(negedge clk);
        @(negedge clk);
        hold = 1'b1;
        @(negedge clk);
        ref_hex = hex;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            checks++;
            if (hex !== ref_hex || hex !== m_hex) begin
                errors++;
                $display("FAIL pause_frozen got %h want %h model %h",
                         hex, ref_hex, m_hex);
            end
        end
        hold = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if (hex !== m_hex || scroll_wrap !== m_wrap) begin
                errors++;
                $display("FAIL pause_resume got %h/%b want %h/%b",
                         hex, scroll_wrap, m_hex, m_wrap);
            end
        end
        scroll_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        want = {seg_of(1), seg_of(2), seg_of(3), seg_of(4)};
        checks++;
        if (hex !== want) begin
            errors++;
            $display("FAIL pause_exit got %h want %h", hex, want);
        end
    endtask

    task automatic test_blink();
        int nb [ND];
        blink_mask = 4'b0101;
        for (int i = 0; i < ND; i++) nb[i] = 0;
        @(negedge clk);
        @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            checks++;
            if (hex !== m_hex) begin
                errors++;
                $display("FAIL blink_model got %h want %h", hex, m_hex);
            end
            for (int i = 0; i < ND; i++)
                if (hex[7*i +: 7] == 7'h7F) nb[i]++;
        end
        for (int i = 0; i < ND; i++) begin
            checks++;
            if (nb[i] != (i % 2 == 0 ? 8 : 0)) begin
                errors++;
                $display("FAIL blink_digit%0d blanks got %0d want %0d",
                         i, nb[i], (i % 2 == 0 ? 8 : 0));
            end
        end
        blink_mask = 4'b0000;
    endtask

    task automatic test_clamp_reset();
        logic [6:0] seq [$];
        logic [6:0] prev;
        int wh;
        int found;
        for (int r = 0; r < 2; r++) begin
            scroll_en = 1'b0;
            @(negedge clk);
            @(negedge clk);
            scroll_len = (r == 0) ? 4'd2 : 4'd0;
            scroll_en  = 1'b1;
            seq.delete();
            prev = hex[27:21];
            seq.push_back(prev);
            wh = 0;
            for (int c = 0; c < 40 && seq.size() < 5; c++) begin
                @(negedge clk);
                checks++;
                if (hex !== m_hex || scroll_wrap !== m_wrap) begin
                    errors++;
                    $display("FAIL clamp_model got %h/%b want %h/%b",
                             hex, scroll_wrap, m_hex, m_wrap);
                end
                if (scroll_wrap) wh++;
                if (hex[27:21] !== prev) begin
                    prev = hex[27:21];
                    seq.push_back(prev);
                end
            end
            checks++;
            if (seq.size() != 5) begin
                errors++;
                $display("FAIL clamp_timeout len %0d got %0d want 5",
                         scroll_len, seq.size());
            end else begin
                for (int i = 0; i < 5; i++) begin
                    checks++;
                    if (seq[i] !== seg_of((i == 4) ? 1 : i + 1)) begin
                        errors++;
                        $display("FAIL clamp_seq[%0d] got %b want %b",
                                 i, seq[i], seg_of((i == 4) ? 1 : i + 1));
                    end
                end
            end
            checks++;
            if (wh != 1) begin
                errors++;
                $display("FAIL clamp_wrap_count got %0d want 1", wh);
            end
        end
        found = 0;
        for (int c = 0; c < 40 && found == 0; c++) begin
            @(negedge clk);
            if (hex[27:21] == seg_of(3)) found = 1;
        end
        checks++;
        if (found == 0) begin
            errors++;
            $display("FAIL midrst_timeout got %b want %b",
                     hex[27:21], seg_of(3));
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (hex !== 28'hFFFFFFF || scroll_wrap !== 1'b0) begin
            errors++;
            $display("FAIL midrst_hex got %h/%b want %h/0",
                     hex, scroll_wrap, 28'hFFFFFFF);
        end
        put(0, 9);
        put(1, 8);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (hex !== m_hex || scroll_wrap !== m_wrap) begin
                errors++;
                $display("FAIL midrst_model got %h/%b want %h/%b",
                         hex, scroll_wrap, m_hex, m_wrap);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst        = ($urandom_range(0, 99) == 0);
            wr_en      = ($urandom_range(0, 2) == 0);
            wr_addr    = 3'($urandom_range(0, 7));
            wr_code    = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 15) == 0) scroll_en = ~scroll_en;
            if ($urandom_range(0, 7) == 0)  hold = ~hold;
            if ($urandom_range(0, 19) == 0)
                scroll_len = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0)
                blink_mask = 4'($urandom_range(0, 15));
            @(negedge clk);
            checks++;
            if (hex !== m_hex || scroll_wrap !== m_wrap) begin
                errors++;
                $display("FAIL random_model cyc %0d got %h/%b want %h/%b",
                         c, hex, scroll_wrap, m_hex, m_wrap);
            end
        end
        rst   = 1'b0;
        wr_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_code    = '0;
        scroll_en  = 1'b0;
        hold       = 1'b0;
        scroll_len = 4'd4;
        blink_mask = 4'b0000;
        test_reset();
        test_static();
        test_scroll();
        test_pause();
        test_blink();
        test_clamp_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
